// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters with round-robin grant, abort and result return.
// Latency: ack one cycle after grant, done one cycle after div_ready_i; owner holds done until it drops req.
// Optional one-entry result cache: define DIV_ARB_RESULT_CACHE_EN.
module div_arbiter #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req0,
    input  logic            req1,
    input  logic            signed0,
    input  logic            signed1,
    input  logic [DW-1:0]   a0,
    input  logic [DW-1:0]   a1,
    input  logic [DW-1:0]   b0,
    input  logic [DW-1:0]   b1,
    output logic            ack0,
    output logic            ack1,
    output logic            done0,
    output logic            done1,
    output logic [2*DW-1:0] result0,
    output logic [2*DW-1:0] result1,
    output logic            div_start_o,
    output logic            div_signed_o,
    output logic [DW-1:0]   div_op1_o,
    output logic [DW-1:0]   div_op2_o,
    output logic            div_annul_o,
    input  logic [2*DW-1:0] div_result_i,
    input  logic            div_ready_i,
    output logic            busy_o,
    output logic            owner_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            rr_q, rr_d;
    logic            signed_q, signed_d;
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic            ack_q, ack_d;
    logic            annul_q, annul_d;
    logic [2*DW-1:0] res_q, res_d;

    logic            req_own;
    logic            win;
    logic            win_signed;
    logic [DW-1:0]   win_a;
    logic [DW-1:0]   win_b;
    logic            grant;
    logic            hit;
    logic [2*DW-1:0] hit_res;

    assign req_own    = owner_q ? req1 : req0;
    // Contention is settled by the pointer; a lone requester always wins.
    assign win        = (req0 & req1) ? rr_q : req1;
    assign win_signed = win ? signed1 : signed0;
    assign win_a      = win ? a1 : a0;
    assign win_b      = win ? b1 : b0;
    assign grant      = (state_q == IDLE) && (req0 | req1) && !flush;

`ifdef DIV_ARB_RESULT_CACHE_EN
    logic            c_vld_q;
    logic            c_sgn_q;
    logic [DW-1:0]   c_a_q;
    logic [DW-1:0]   c_b_q;
    logic [2*DW-1:0] c_res_q;

    assign hit     = c_vld_q && (c_sgn_q == win_signed) && (c_a_q == win_a) && (c_b_q == win_b);
    assign hit_res = c_res_q;

    // Only divider-sourced results are cached; flush leaves the entry intact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_vld_q <= 1'b0;
            c_sgn_q <= 1'b0;
            c_a_q   <= '0;
            c_b_q   <= '0;
            c_res_q <= '0;
        end else if (state_q == RUN && state_d == RESP) begin
            c_vld_q <= 1'b1;
            c_sgn_q <= signed_q;
            c_a_q   <= op1_q;
            c_b_q   <= op2_q;
            c_res_q <= div_result_i;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        res_d    = res_q;
        ack_d    = 1'b0;
        annul_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d  = win;
                    signed_d = win_signed;
                    op1_d    = win_a;
                    op2_d    = win_b;
                    ack_d    = 1'b1;
                    if (hit) begin
                        res_d   = hit_res;
                        state_d = RESP;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Abort wins over a coincident div_ready_i.
                if (flush || !req_own) begin
                    annul_d = 1'b1;
                    state_d = IDLE;
                end else if (div_ready_i) begin
                    res_d   = div_result_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!req_own) begin
                    rr_d    = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            ack_q    <= 1'b0;
            annul_q  <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            ack_q    <= ack_d;
            annul_q  <= annul_d;
            res_q    <= res_d;
        end
    end

    assign ack0         = ack_q & ~owner_q;
    assign ack1         = ack_q & owner_q;
    assign done0        = (state_q == RESP) & ~owner_q;
    assign done1        = (state_q == RESP) & owner_q;
    assign result0      = done0 ? res_q : '0;
    assign result1      = done1 ? res_q : '0;
    assign div_start_o  = (state_q == RUN);
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign div_annul_o  = annul_q;
    assign busy_o       = (state_q != IDLE);
    assign owner_o      = owner_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider with fixed latency, expected results kept in a queue.
module tb_div_arbiter;
    localparam int DW      = 32;
    localparam int DIV_LAT = 20;

    typedef struct packed {
        logic        port;
        logic [63:0] res;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, signed0 = 1'b0, signed1 = 1'b0;
    logic [DW-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic          ack0, ack1, done0, done1;
    logic [63:0]   result0, result1;
    logic          div_start_o, div_signed_o, div_annul_o, busy_o, owner_o;
    logic [DW-1:0] div_op1_o, div_op2_o;
    logic [63:0]   div_result_i = '0;
    logic          div_ready_i = 1'b0;
    int            div_cnt = 0;
    int            checks = 0;
    int            errors = 0;
    exp_t          exp_q[$];

    div_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0(req0), .req1(req1), .signed0(signed0), .signed1(signed1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result0(result0), .result1(result1),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_annul_o(div_annul_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider: result appears DIV_LAT cycles after start rises, held while start stays high.
    always @(posedge clk) begin
        if (!div_start_o) begin
            div_cnt     <= 0;
            div_ready_i <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1;
            if (div_cnt == DIV_LAT - 1) begin
                div_ready_i  <= 1'b1;
                div_result_i <= div_model(div_signed_o, div_op1_o, div_op2_o);
            end
        end
    end

`ifdef DIV_ARB_RESULT_CACHE_EN
    int start_rises = 0;
    always @(posedge div_start_o) start_rises++;
`endif

    function automatic logic ack_of(input logic p);
        return p ? ack1 : ack0;
    endfunction
    function automatic logic done_of(input logic p);
        return p ? done1 : done0;
    endfunction
    function automatic logic [63:0] res_of(input logic p);
        return p ? result1 : result0;
    endfunction

    task automatic set_port(input logic p, input logic r, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (p) begin req1 = r; signed1 = s; a1 = a; b1 = b; end
        else   begin req0 = r; signed0 = s; a0 = a; b0 = b; end
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; flush = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(input logic p);
        int n = 0;
        while (ack_of(p) !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (ack_of(p) !== 1'b1) begin
            errors++; $display("FAIL ack_timeout port%0d: ack=%b required 1", p, ack_of(p));
        end
        checks++;
        if (ack_of(!p) !== 1'b0 || owner_o !== p) begin
            errors++; $display("FAIL grant_owner port%0d: other_ack=%b owner=%b required 0/%0d", p, ack_of(!p), owner_o, p);
        end
    endtask

    task automatic wait_done();
        int   n = 0;
        exp_t e;
        while (done0 !== 1'b1 && done1 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL scoreboard_empty: done0=%b done1=%b required no done", done0, done1);
        end else begin
            e = exp_q.pop_front();
            if (done_of(e.port) !== 1'b1 || done_of(!e.port) !== 1'b0 || res_of(e.port) !== e.res || res_of(!e.port) !== 64'd0) begin
                errors++;
                $display("FAIL result port%0d: done=%b/%b res=%h other_res=%h required done on port%0d res=%h",
                         e.port, done0, done1, res_of(e.port), res_of(!e.port), e.port, e.res);
            end
        end
        checks++;
        if (div_start_o !== 1'b0) begin
            errors++; $display("FAIL start_in_resp: div_start_o=%b required 0", div_start_o);
        end
    endtask

    task automatic release_req(input logic p);
        if (p) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (done_of(p) !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL release port%0d: done=%b busy=%b required 0/0", p, done_of(p), busy_o);
        end
    endtask

    task automatic run_op(input logic p, input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_res);
        exp_q.push_back('{port: p, res: exp_res});
        set_port(p, 1'b1, s, a, b);
        wait_ack(p);
        checks++;
        if (div_start_o !== 1'b1 || div_op1_o !== a || div_op2_o !== b || div_signed_o !== s) begin
            errors++;
            $display("FAIL div_launch: start=%b op1=%h op2=%h sgn=%b required 1/%h/%h/%b",
                     div_start_o, div_op1_o, div_op2_o, div_signed_o, a, b, s);
        end
        @(negedge clk);
        checks++;
        if (ack_of(p) !== 1'b0) begin
            errors++; $display("FAIL ack_pulse port%0d: ack=%b required 0", p, ack_of(p));
        end
        wait_done();
        release_req(p);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ack0, ack1, done0, done1, result0, result1, div_start_o, div_signed_o,
             div_op1_o, div_op2_o, div_annul_o, busy_o, owner_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero, busy=%b start=%b res0=%h", busy_o, div_start_o, result0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || owner_o !== 1'b0) begin
            errors++; $display("FAIL post_reset: busy=%b owner=%b required 0/0", busy_o, owner_o);
        end
    endtask

    task automatic test_signed();
        run_op(1'b0, 1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                exp_q.push_back('{port: 1'b0, res: {32'd1, 32'd7}});
                exp_q.push_back('{port: 1'b1, res: {32'd2, 32'd6}});
                set_port(1'b0, 1'b1, 1'b0, 32'd50, 32'd7);
                set_port(1'b1, 1'b1, 1'b0, 32'd20, 32'd3);
            end else begin
                exp_q.push_back('{port: 1'b0, res: {32'd2, 32'd7}});
                exp_q.push_back('{port: 1'b1, res: {32'd4, 32'd6}});
                set_port(1'b0, 1'b1, 1'b0, 32'd30, 32'd4);
                set_port(1'b1, 1'b1, 1'b0, 32'd40, 32'd6);
            end
            wait_ack(1'b0);
            wait_done();
            release_req(1'b0);
            wait_ack(1'b1);
            wait_done();
            release_req(1'b1);
        end
    endtask

    task automatic test_flush_run();
        set_port(1'b0, 1'b1, 1'b1, -32'sd100, 32'd9);
        wait_ack(1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1; req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (div_annul_o !== 1'b1 || div_start_o !== 1'b0 || busy_o !== 1'b0 || done0 !== 1'b0) begin
            errors++; $display("FAIL flush_abort: annul=%b start=%b busy=%b done0=%b required 1/0/0/0",
                               div_annul_o, div_start_o, busy_o, done0);
        end
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (div_annul_o !== 1'b0) begin
            errors++; $display("FAIL annul_pulse: annul=%b required 0", div_annul_o);
        end
        run_op(1'b0, 1'b1, -32'sd100, 32'd9, {32'hFFFF_FFFF, 32'hFFFF_FFF5});
    endtask

    task automatic test_flush_ready();
        int n = 0;
        set_port(1'b1, 1'b1, 1'b0, 32'd9, 32'd2);
        wait_ack(1'b1);
        while (div_ready_i !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (div_ready_i !== 1'b1) begin
            errors++; $display("FAIL ready_timeout: div_ready_i=%b required 1", div_ready_i);
        end
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (div_annul_o !== 1'b1 || done1 !== 1'b0 || busy_o !== 1'b0 || result1 !== 64'd0) begin
            errors++; $display("FAIL flush_ready: annul=%b done1=%b busy=%b res1=%h required 1/0/0/0",
                               div_annul_o, done1, busy_o, result1);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ack1 !== 1'b0) begin
            errors++; $display("FAIL flush_idle_grant: busy=%b ack1=%b required 0/0", busy_o, ack1);
        end
        req1 = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL flush_ready_after: done1=%b busy=%b required 0/0", done1, busy_o);
        end
    endtask

    task automatic test_div_zero();
        run_op(1'b1, 1'b0, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
    endtask

`ifdef DIV_ARB_RESULT_CACHE_EN
    task automatic test_cache();
        int starts;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        starts = start_rises;
        exp_q.push_back('{port: 1'b0, res: {32'd2, 32'd14}});
        set_port(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || done0 !== 1'b1) begin
            errors++; $display("FAIL cache_hit_timing: ack0=%b done0=%b required 1/1", ack0, done0);
        end
        wait_done();
        checks++;
        if (start_rises != starts) begin
            errors++; $display("FAIL cache_no_start: start rises=%0d required %0d", start_rises, starts);
        end
        release_req(1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_signed();
        test_round_robin();
        test_flush_run();
        test_flush_ready();
        test_div_zero();
`ifdef DIV_ARB_RESULT_CACHE_EN
        test_cache();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
